// File: rtl/cifra_aes_iterativa.sv
// cifra_aes_iterativa: iterative AES-128 encrypt, one round per clock; inicio starts a block, pronto pulses with textoCifrado, ocupado while busy
module cifra_aes_iterativa #(
  parameter int NUM_RODADAS = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inicio,
  input  logic [127:0]  textoClaro,
  input  logic [127:0]  chave,
  input  logic [1279:0] chaveExpandida,
  output logic          ocupado,
  output logic          pronto,
  output logic [127:0]  textoCifrado
);
  typedef enum logic {OCIOSO, RODADA} estado_t;
  localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p, r;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  estado_t estado_q, estado_d;
  logic [3:0] rodada_q, rodada_d;
  logic [127:0] estado_aes_q, estado_aes_d;
  logic [1279:0] chave_exp_q, chave_exp_d;
  logic ocupado_q, ocupado_d, pronto_q, pronto_d;
  logic [127:0] texto_cifrado_q, texto_cifrado_d;
  logic [127:0] rks [16];
  logic [127:0] sr, mc, resultado;
  logic [7:0] a0, a1, a2, a3;
  always_comb begin
    for (int k = 0; k < 16; k++) rks[k] = '0;
    for (int k = 0; k < 10; k++)
      for (int r = 0; r < 4; r++) rks[k][32*r +: 32] = chave_exp_q[320*r + 32*k +: 32];
  end
  always_comb begin
    sr = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sr[32*r + 8*c +: 8] = sbox(estado_aes_q[32*r + 8*((c + r) % 4) +: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = sr[8*c +: 8];
      a1 = sr[32 + 8*c +: 8];
      a2 = sr[64 + 8*c +: 8];
      a3 = sr[96 + 8*c +: 8];
      mc[8*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[32 + 8*c +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[64 + 8*c +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[96 + 8*c +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    resultado = (rodada_q == ULTIMA ? sr : mc) ^ rks[rodada_q - 4'd1];
  end
  always_comb begin
    estado_d        = estado_q;
    rodada_d        = rodada_q;
    estado_aes_d    = estado_aes_q;
    chave_exp_d     = chave_exp_q;
    ocupado_d       = ocupado_q;
    pronto_d        = 1'b0;
    texto_cifrado_d = texto_cifrado_q;
    if (estado_q == OCIOSO) begin
      if (inicio) begin
        estado_aes_d = textoClaro ^ chave;
        chave_exp_d  = chaveExpandida;
        rodada_d     = 4'd1;
        ocupado_d    = 1'b1;
        estado_d     = RODADA;
      end
    end else if (rodada_q == ULTIMA) begin
      estado_aes_d    = resultado;
      texto_cifrado_d = resultado;
      pronto_d        = 1'b1;
      ocupado_d       = 1'b0;
      rodada_d        = 4'd0;
      estado_d        = OCIOSO;
    end else if (rodada_q != 4'd0 && rodada_q < ULTIMA) begin
      estado_aes_d = resultado;
      rodada_d     = rodada_q + 4'd1;
    end else begin
      // unreachable round count: drop the block rather than run off the key table
      ocupado_d = 1'b0;
      rodada_d  = 4'd0;
      estado_d  = OCIOSO;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      rodada_q        <= '0;
      estado_aes_q    <= '0;
      chave_exp_q     <= '0;
      ocupado_q       <= 1'b0;
      pronto_q        <= 1'b0;
      texto_cifrado_q <= '0;
    end else begin
      estado_q        <= estado_d;
      rodada_q        <= rodada_d;
      estado_aes_q    <= estado_aes_d;
      chave_exp_q     <= chave_exp_d;
      ocupado_q       <= ocupado_d;
      pronto_q        <= pronto_d;
      texto_cifrado_q <= texto_cifrado_d;
    end
  end
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign textoCifrado = texto_cifrado_q;
endmodule

// File: tb/tb_cifra_aes_iterativa.sv
// tb_cifra_aes_iterativa: scoreboard bench for the iterative AES-128 cipher against FIPS-197 vectors
module tb_cifra_aes_iterativa;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inicio = 1'b0;
  logic [127:0] textoClaro = '0;
  logic [127:0] chave = '0;
  logic [1279:0] chaveExpandida = '0;
  logic ocupado, pronto;
  logic [127:0] textoCifrado;
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  cifra_aes_iterativa dut (
    .clock(clock), .reset(reset), .inicio(inicio), .textoClaro(textoClaro), .chave(chave),
    .chaveExpandida(chaveExpandida), .ocupado(ocupado), .pronto(pronto), .textoCifrado(textoCifrado));
  always #5 clock = ~clock;
  function automatic logic [127:0] to_dut(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[32*(n%4) + 8*(n/4) +: 8] = v[127-8*n -: 8];
    return o;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
  endfunction
  function automatic logic [1279:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1279:0] ce;
    rc = 8'h01;
    ce = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 1; k <= 10; k++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) ce[320*r + 8*(4*(k-1)+c) +: 8] = w[4*k+c][31-8*r -: 8];
    return ce;
  endfunction
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic start(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
    textoClaro = to_dut(pt);
    chave = to_dut(key);
    chaveExpandida = expand(key);
    inicio = 1'b1;
    exp_q.push_back(to_dut(ct));
  endtask
  task automatic wait_pronto(output int n, output int occ);
    n = 0;
    occ = 0;
    while (!pronto && n < 30) begin
      occ += int'(ocupado);
      step;
      n++;
    end
  endtask
  function automatic logic [127:0] pop_exp();
    return exp_q.size() != 0 ? exp_q.pop_front() : 'x;
  endfunction
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) step;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b expected 0", ocupado); end
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got %b expected 0", pronto); end
    checks++; if (textoCifrado !== '0) begin errors++; $display("FAIL reset_ct got %h expected 0", textoCifrado); end
    reset = 1'b0;
    step;
  endtask
  task automatic test_fips_b;
    int n, occ;
    logic [127:0] e;
    start(PT1, KEY1, CT1);
    step;
    inicio = 1'b0;
    checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL b_ocupado_after_start got %b expected 1", ocupado); end
    wait_pronto(n, occ);
    checks++; if (n != 10) begin errors++; $display("FAIL b_latency got %0d expected 10", n); end
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL b_ct got %h expected %h", textoCifrado, e); end
    step;
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL b_pronto_width got %b expected 0", pronto); end
  endtask
  task automatic test_fips_c1;
    int n, occ;
    logic [127:0] e;
    start(PT2, KEY2, CT2);
    step;
    inicio = 1'b0;
    wait_pronto(n, occ);
    checks++; if (occ != 10) begin errors++; $display("FAIL c1_ocupado_cycles got %0d expected 10", occ); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL c1_ocupado_at_pronto got %b expected 0", ocupado); end
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL c1_ct got %h expected %h", textoCifrado, e); end
    step;
  endtask
  task automatic test_back_to_back;
    int n, occ;
    logic [127:0] e;
    start(PT1, KEY1, CT1);
    step;
    inicio = 1'b0;
    wait_pronto(n, occ);
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_first_latency got %0d expected 10", n); end
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL b2b_first_ct got %h expected %h", textoCifrado, e); end
    start(PT2, KEY2, CT2);
    step;
    inicio = 1'b0;
    checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b expected 1", ocupado); end
    wait_pronto(n, occ);
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_second_latency got %0d expected 10", n); end
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL b2b_second_ct got %h expected %h", textoCifrado, e); end
    step;
  endtask
  task automatic test_inicio_held;
    int n;
    logic [127:0] e;
    start(PT1, KEY1, CT1);
    step;
    n = 0;
    while (!pronto && n < 30) begin
      textoClaro = {$urandom, $urandom, $urandom, $urandom};
      chave = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 40; i++) chaveExpandida[32*i +: 32] = $urandom;
      step;
      n++;
    end
    inicio = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL held_latency got %0d expected 10", n); end
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL held_ct got %h expected %h", textoCifrado, e); end
    step;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL held_no_restart got %b expected 0", ocupado); end
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL held_ct_hold got %h expected %h", textoCifrado, e); end
  endtask
  task automatic test_reset_mid;
    int n, occ;
    logic [127:0] e;
    start(PT1, KEY1, CT1);
    step;
    inicio = 1'b0;
    repeat (5) step;
    checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", ocupado); end
    reset = 1'b1;
    step;
    reset = 1'b0;
    exp_q.delete();
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL mid_reset_ocupado got %b expected 0", ocupado); end
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL mid_reset_pronto got %b expected 0", pronto); end
    checks++; if (textoCifrado !== '0) begin errors++; $display("FAIL mid_reset_ct got %h expected 0", textoCifrado); end
    start(PT2, KEY2, CT2);
    step;
    inicio = 1'b0;
    wait_pronto(n, occ);
    checks++; if (n != 10) begin errors++; $display("FAIL mid_after_latency got %0d expected 10", n); end
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL mid_after_ct got %h expected %h", textoCifrado, e); end
    step;
  endtask
  task automatic test_zero;
    int n, occ;
    logic [127:0] e;
    start(128'h0, 128'h0, CT0);
    step;
    inicio = 1'b0;
    wait_pronto(n, occ);
    e = pop_exp();
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL zero_ct got %h expected %h", textoCifrado, e); end
    repeat (3) step;
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL zero_pronto_low got %b expected 0", pronto); end
    checks++; if (textoCifrado !== e) begin errors++; $display("FAIL zero_ct_hold got %h expected %h", textoCifrado, e); end
  endtask
  initial begin
    test_reset;
    test_fips_b;
    test_fips_c1;
    test_back_to_back;
    test_inicio_held;
    test_reset_mid;
    test_zero;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
